// File: rtl/rtc_bus_sequencer.sv
// rtc_bus_sequencer: round-robin sharer of the multiplexed-address RTC bus.
// Requester A (command registers) and requester B (refresh scanner) each get
// one full address-phase + data-phase transaction per grant.
// Ports:
//   clk, reset            rising-edge clock, synchronous active-low reset
//   a_* / b_*             req/wr/addr/wdata in; gnt/done 1-cycle pulses out
//   rdata                 data of the last completed read
//   AD, CS, WR, RD        RTC bus control (AD 0=address phase; strobes active low)
//   bus_out/bus_oe/bus_in split bidirectional data bus (pad lives at top level)
//   busy                  high from grant until the bus is free for arbitration
module rtc_bus_sequencer #(
  parameter int unsigned N        = 8,
  parameter int unsigned T_SETUP  = 2,
  parameter int unsigned T_STROBE = 4,
  parameter int unsigned T_HOLD   = 2,
  parameter int unsigned T_GAP    = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         a_req,
  input  logic         a_wr,
  input  logic [N-1:0] a_addr,
  input  logic [N-1:0] a_wdata,
  output logic         a_gnt,
  output logic         a_done,
  input  logic         b_req,
  input  logic         b_wr,
  input  logic [N-1:0] b_addr,
  input  logic [N-1:0] b_wdata,
  output logic         b_gnt,
  output logic         b_done,
  output logic [N-1:0] rdata,
  output logic         AD,
  output logic         CS,
  output logic         WR,
  output logic         RD,
  output logic [N-1:0] bus_out,
  output logic         bus_oe,
  input  logic [N-1:0] bus_in,
  output logic         busy
);

  localparam int unsigned T_MAX1   = (T_SETUP > T_STROBE) ? T_SETUP : T_STROBE;
  localparam int unsigned T_MAX2   = (T_HOLD > T_GAP) ? T_HOLD : T_GAP;
  localparam int unsigned T_MAX    = (T_MAX1 > T_MAX2) ? T_MAX1 : T_MAX2;
  localparam int unsigned CW       = $clog2(T_MAX + 1);
  // The IDLE arbitration cycle is the last gap cycle, so GAP itself lasts T_GAP-1.
  localparam int unsigned GAP_LOAD = (T_GAP > 1) ? T_GAP - 2 : 0;

  typedef enum logic [3:0] {
    S_IDLE, S_A_SETUP, S_A_STROBE, S_A_HOLD,
    S_D_SETUP, S_D_STROBE, S_D_HOLD, S_DONE, S_GAP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          prio_b_q, prio_b_d;
  logic          cmd_b_q, cmd_b_d;
  logic          cmd_wr_q, cmd_wr_d;
  logic [N-1:0]  cmd_addr_q, cmd_addr_d;
  logic [N-1:0]  cmd_wdata_q, cmd_wdata_d;
  logic          grant_a, grant_b, cnt_zero;
  logic          a_gnt_d, b_gnt_d, a_done_d, b_done_d, busy_d;
  logic          ad_d, cs_d, wr_d, rd_d, oe_d;
  logic [N-1:0]  bus_out_d, rdata_d;

  // Next state, command latch and next registered outputs
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    prio_b_d    = prio_b_q;
    cmd_b_d     = cmd_b_q;
    cmd_wr_d    = cmd_wr_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    grant_a     = 1'b0;
    grant_b     = 1'b0;
    rdata_d     = rdata;
    cnt_zero    = (cnt_q == '0);

    case (state_q)
      S_IDLE: begin
        if (a_req && (!b_req || !prio_b_q)) grant_a = 1'b1;
        else if (b_req)                     grant_b = 1'b1;
        if (grant_a || grant_b) begin
          state_d = S_A_SETUP;
          cnt_d   = CW'(T_SETUP - 1);
        end
      end
      S_A_SETUP: begin
        if (cnt_zero) begin state_d = S_A_STROBE; cnt_d = CW'(T_STROBE - 1); end
        else cnt_d = cnt_q - CW'(1);
      end
      S_A_STROBE: begin
        if (cnt_zero) begin state_d = S_A_HOLD; cnt_d = CW'(T_HOLD - 1); end
        else cnt_d = cnt_q - CW'(1);
      end
      S_A_HOLD: begin
        if (cnt_zero) begin state_d = S_D_SETUP; cnt_d = CW'(T_SETUP - 1); end
        else cnt_d = cnt_q - CW'(1);
      end
      S_D_SETUP: begin
        if (cnt_zero) begin state_d = S_D_STROBE; cnt_d = CW'(T_STROBE - 1); end
        else cnt_d = cnt_q - CW'(1);
      end
      S_D_STROBE: begin
        if (cnt_zero) begin
          state_d = S_D_HOLD;
          cnt_d   = CW'(T_HOLD - 1);
          if (!cmd_wr_q) rdata_d = bus_in;
        end else cnt_d = cnt_q - CW'(1);
      end
      S_D_HOLD: begin
        if (cnt_zero) state_d = S_DONE;
        else cnt_d = cnt_q - CW'(1);
      end
      S_DONE: begin
        if (T_GAP > 1) begin state_d = S_GAP; cnt_d = CW'(GAP_LOAD); end
        else state_d = S_IDLE;
      end
      S_GAP: begin
        if (cnt_zero) state_d = S_IDLE;
        else cnt_d = cnt_q - CW'(1);
      end
      default: state_d = S_IDLE;
    endcase

    // Latch the winner's command; the pointer then favours the other requester
    if (grant_a || grant_b) begin
      cmd_b_d     = grant_b;
      cmd_wr_d    = grant_b ? b_wr    : a_wr;
      cmd_addr_d  = grant_b ? b_addr  : a_addr;
      cmd_wdata_d = grant_b ? b_wdata : a_wdata;
      prio_b_d    = grant_a;
    end

    a_gnt_d   = grant_a;
    b_gnt_d   = grant_b;
    a_done_d  = (state_d == S_DONE) && (state_q != S_DONE) && !cmd_b_d;
    b_done_d  = (state_d == S_DONE) && (state_q != S_DONE) &&  cmd_b_d;
    busy_d    = (state_d != S_IDLE);
    ad_d      = 1'b1;
    cs_d      = 1'b1;
    wr_d      = 1'b1;
    rd_d      = 1'b1;
    oe_d      = 1'b0;
    bus_out_d = '0;

    // Bus pins follow the state being entered so they change on state edges
    case (state_d)
      S_A_SETUP, S_A_HOLD: begin
        ad_d = 1'b0; oe_d = 1'b1; bus_out_d = cmd_addr_d;
      end
      S_A_STROBE: begin
        ad_d = 1'b0; oe_d = 1'b1; bus_out_d = cmd_addr_d;
        cs_d = 1'b0; wr_d = 1'b0;
      end
      S_D_SETUP, S_D_HOLD: begin
        if (cmd_wr_d) begin oe_d = 1'b1; bus_out_d = cmd_wdata_d; end
      end
      S_D_STROBE: begin
        cs_d = 1'b0;
        if (cmd_wr_d) begin oe_d = 1'b1; bus_out_d = cmd_wdata_d; wr_d = 1'b0; end
        else rd_d = 1'b0;
      end
      default: ;
    endcase
  end

  // State, command and output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      prio_b_q    <= 1'b0;
      cmd_b_q     <= 1'b0;
      cmd_wr_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      a_gnt       <= 1'b0;
      b_gnt       <= 1'b0;
      a_done      <= 1'b0;
      b_done      <= 1'b0;
      busy        <= 1'b0;
      AD          <= 1'b1;
      CS          <= 1'b1;
      WR          <= 1'b1;
      RD          <= 1'b1;
      bus_oe      <= 1'b0;
      bus_out     <= '0;
      rdata       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prio_b_q    <= prio_b_d;
      cmd_b_q     <= cmd_b_d;
      cmd_wr_q    <= cmd_wr_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      a_gnt       <= a_gnt_d;
      b_gnt       <= b_gnt_d;
      a_done      <= a_done_d;
      b_done      <= b_done_d;
      busy        <= busy_d;
      AD          <= ad_d;
      CS          <= cs_d;
      WR          <= wr_d;
      RD          <= rd_d;
      bus_oe      <= oe_d;
      bus_out     <= bus_out_d;
      rdata       <= rdata_d;
    end
  end

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Bench for rtc_bus_sequencer: directed scenarios plus random traffic, every
// cycle compared against a cycle-index reference model of one transaction.
module tb_rtc_bus_sequencer;

  localparam int unsigned N = 8;
  localparam int TS = 2, TSTR = 4, TH = 2, TG = 2;
  localparam int P1 = TS, P2 = P1 + TSTR, P3 = P2 + TH;
  localparam int P4 = P3 + TS, P5 = P4 + TSTR, P6 = P5 + TH;
  localparam int K_DONE = P6 + 1;
  localparam int K_NEXT = K_DONE + TG;
  localparam int OW = 10 + 2 * N;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset = 1'b0;
  logic         a_req = 0, a_wr = 0, b_req = 0, b_wr = 0;
  logic [N-1:0] a_addr = 0, a_wdata = 0, b_addr = 0, b_wdata = 0, bus_in = 0;
  logic         a_gnt, a_done, b_gnt, b_done, busy, AD, CS, WR, RD, bus_oe;
  logic [N-1:0] rdata, bus_out;

  logic         f_a_req = 0, f_a_wr = 0, f_b_req = 0, f_b_wr = 0;
  logic [N-1:0] f_a_addr = 0, f_a_wdata = 0, f_b_addr = 0, f_b_wdata = 0;
  logic         f_a_gnt, f_a_done, f_b_gnt, f_b_done, f_busy, f_ad, f_cs, f_wr, f_rd, f_oe;
  logic [N-1:0] f_rdata, f_bus_out;

  rtc_bus_sequencer #(.N(N), .T_SETUP(TS), .T_STROBE(TSTR), .T_HOLD(TH), .T_GAP(TG)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_wdata(a_wdata), .a_gnt(a_gnt), .a_done(a_done),
    .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_wdata(b_wdata), .b_gnt(b_gnt), .b_done(b_done),
    .rdata(rdata), .AD(AD), .CS(CS), .WR(WR), .RD(RD),
    .bus_out(bus_out), .bus_oe(bus_oe), .bus_in(bus_in), .busy(busy)
  );

  rtc_bus_sequencer #(.N(N), .T_SETUP(1), .T_STROBE(1), .T_HOLD(1), .T_GAP(1)) dut_fast (
    .clk(clk), .reset(reset),
    .a_req(f_a_req), .a_wr(f_a_wr), .a_addr(f_a_addr), .a_wdata(f_a_wdata), .a_gnt(f_a_gnt), .a_done(f_a_done),
    .b_req(f_b_req), .b_wr(f_b_wr), .b_addr(f_b_addr), .b_wdata(f_b_wdata), .b_gnt(f_b_gnt), .b_done(f_b_done),
    .rdata(f_rdata), .AD(f_ad), .CS(f_cs), .WR(f_wr), .RD(f_rd),
    .bus_out(f_bus_out), .bus_oe(f_oe), .bus_in(bus_in), .busy(f_busy)
  );

  int n_checks = 0, n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: a transaction is just "k cycles since its grant edge"
  bit           m_act = 0, m_b = 0, m_wr = 0, m_last_a = 0;
  int           m_k = 0;
  logic [N-1:0] m_addr = 0, m_wdata = 0, m_rdata = 0;

  task automatic model_edge();
    if (!reset) begin
      m_act = 0; m_last_a = 0; m_rdata = '0;
    end else if (!m_act) begin
      if (a_req || b_req) begin
        m_b      = b_req && (!a_req || m_last_a);
        m_wr     = m_b ? b_wr : a_wr;
        m_addr   = m_b ? b_addr : a_addr;
        m_wdata  = m_b ? b_wdata : a_wdata;
        m_last_a = !m_b;
        m_act    = 1;
        m_k      = 1;
      end
    end else begin
      if (m_k == P5 && !m_wr) m_rdata = bus_in;
      m_k++;
      if (m_k == K_NEXT) m_act = 0;
    end
  endtask

  function automatic logic [OW-1:0] model_out();
    logic addr_ph, a_str, d_ph, d_str, oe;
    logic [N-1:0] bo;
    addr_ph = m_act && m_k <= P3;
    a_str   = m_act && m_k > P1 && m_k <= P2;
    d_ph    = m_act && m_k > P3 && m_k <= P6;
    d_str   = m_act && m_k > P4 && m_k <= P5;
    oe      = addr_ph || (d_ph && m_wr);
    bo      = addr_ph ? m_addr : (oe ? m_wdata : '0);
    return {m_act && m_k == 1 && !m_b, m_act && m_k == K_DONE && !m_b,
            m_act && m_k == 1 && m_b,  m_act && m_k == K_DONE && m_b,
            m_act, !addr_ph, !(a_str || d_str), !(a_str || (d_str && m_wr)),
            !(d_str && !m_wr), oe, bo, m_rdata};
  endfunction

  // Cycle bookkeeping for directed latency checks
  int tcyc = 0, cyc = 0, done_k = 0, n_gnt = 0, overlap = 0;
  bit done_seen = 0, done_b = 0;
  int gnt_who[8], gnt_t[8];
  int f_cyc = 0, f_done_k = 0, f_overlap = 0;
  bit f_done_seen = 0;

  task automatic compare();
    logic [OW-1:0] e, g;
    e = model_out();
    g = {a_gnt, a_done, b_gnt, b_done, busy, AD, CS, WR, RD, bus_oe,
         (e[2*N] ? bus_out : {N{1'b0}}), rdata};
    check($sformatf("outputs_cycle_%0d", tcyc), 64'(g), 64'(e));
    if (a_gnt || b_gnt) begin
      cyc = 1;
      if (n_gnt < 8) begin gnt_who[n_gnt] = int'(b_gnt); gnt_t[n_gnt] = tcyc; n_gnt++; end
    end else if (cyc != 0) cyc++;
    if (a_done || b_done) begin done_seen = 1; done_k = cyc; done_b = b_done; end
    if (!WR && !RD) overlap++;
    if (f_a_gnt || f_b_gnt) f_cyc = 1;
    else if (f_cyc != 0) f_cyc++;
    if (f_a_done || f_b_done) begin f_done_seen = 1; f_done_k = f_cyc; end
    if (!f_wr && !f_rd) f_overlap++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    tcyc++;
    compare();
  endtask

  // Run one transaction to its done pulse; drop_at>0 releases requests in that cycle
  task automatic run_txn(input int drop_at, output int dk);
    cyc = 0; done_seen = 0; dk = -1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (drop_at != 0 && cyc == drop_at) begin a_req = 0; b_req = 0; end
      if (done_seen) begin dk = done_k; a_req = 0; b_req = 0; break; end
    end
  endtask

  initial begin
    int dk;
    bit no_done;
    logic [OW-1:0] rst_v;

    repeat (3) tick();
    rst_v = {1'b0, 1'b0, 1'b0, 1'b0, busy, AD, CS, WR, RD, bus_oe, bus_out, rdata};
    check("reset_state", 64'(rst_v), 64'({10'b0000011110, {N{1'b0}}, {N{1'b0}}}));
    check("reset_gnt_done", 64'({a_gnt, a_done, b_gnt, b_done}), 64'd0);
    reset = 1;
    tick();

    // A write, B idle
    a_req = 1; a_wr = 1; a_addr = 8'h21; a_wdata = 8'h45;
    run_txn(0, dk);
    check("a_write_done_cycle", 64'(dk), 64'd17);
    check("a_write_done_owner", 64'(done_b), 64'd0);
    repeat (3) tick();

    // B read with turnaround
    b_req = 1; b_wr = 0; b_addr = 8'h42; bus_in = 8'h37;
    run_txn(0, dk);
    check("b_read_done_cycle", 64'(dk), 64'd17);
    check("b_read_rdata", 64'(rdata), 64'h37);
    check("b_read_done_owner", 64'(done_b), 64'd1);
    repeat (3) tick();

    // Simultaneous requests right after reset alternate A,B,A,B
    reset = 0; repeat (2) tick();
    for (int i = 0; i < 8; i++) begin gnt_who[i] = -1; gnt_t[i] = -1000; end
    n_gnt = 0;
    reset = 1; a_req = 1; b_req = 1; a_wr = 1; b_wr = 0; a_addr = 8'h10; b_addr = 8'h20;
    for (int i = 0; i < 120 && n_gnt < 4; i++) begin bus_in = N'($urandom); tick(); end
    a_req = 0; b_req = 0;
    for (int i = 0; i < 4; i++) check($sformatf("alt_grant_%0d_owner", i), 64'(gnt_who[i]), 64'(i % 2));
    for (int i = 1; i < 4; i++) check($sformatf("alt_grant_%0d_spacing", i), 64'(gnt_t[i] - gnt_t[i-1]), 64'(K_NEXT));
    repeat (25) tick();

    // Reset in cycle 12 of an A read aborts it; held A is granted again
    a_req = 1; a_wr = 0; a_addr = 8'h33; cyc = 0; done_seen = 0;
    for (int i = 0; i < 40 && cyc != 12; i++) tick();
    reset = 0;
    tick();
    check("abort_strobes", 64'({CS, RD, WR, bus_oe}), 64'(4'b1110));
    no_done = !done_seen;
    reset = 1;
    check("abort_no_done", 64'(no_done), 64'd1);
    run_txn(0, dk);
    check("abort_regrant_done_cycle", 64'(dk), 64'd17);
    check("abort_regrant_owner", 64'(done_b), 64'd0);
    repeat (3) tick();

    // Committed command survives request drop in cycle 5
    a_req = 1; a_wr = 1; a_addr = 8'h5A; a_wdata = 8'hC3;
    run_txn(5, dk);
    check("drop_req_done_cycle", 64'(dk), 64'd17);
    repeat (3) tick();

    // Minimum-timing instance: write then read
    f_a_req = 1; f_a_wr = 1; f_a_addr = 8'h11; f_a_wdata = 8'h22; f_cyc = 0; f_done_seen = 0; f_done_k = -1;
    for (int i = 0; i < 30 && !f_done_seen; i++) tick();
    f_a_req = 0;
    check("fast_write_done_cycle", 64'(f_done_k), 64'd7);
    tick();
    f_b_req = 1; f_b_wr = 0; f_b_addr = 8'h66; bus_in = 8'h9C; f_cyc = 0; f_done_seen = 0; f_done_k = -1;
    for (int i = 0; i < 30 && !f_done_seen; i++) tick();
    f_b_req = 0;
    check("fast_read_done_cycle", 64'(f_done_k), 64'd7);
    check("fast_read_rdata", 64'(f_rdata), 64'h9C);

    // Random traffic, including pre-grant drops, late input changes and resets
    for (int i = 0; i < 3000; i++) begin
      bus_in = N'($urandom);
      reset  = ($urandom_range(299) != 0);
      if (a_done) a_req = 0;
      else if (!a_req) a_req = ($urandom_range(4) == 0);
      else if ($urandom_range(49) == 0) a_req = 0;
      if (b_done) b_req = 0;
      else if (!b_req) b_req = ($urandom_range(4) == 0);
      else if ($urandom_range(49) == 0) b_req = 0;
      if ($urandom_range(3) == 0) begin a_wr = 1'($urandom); a_addr = N'($urandom); a_wdata = N'($urandom); end
      if ($urandom_range(3) == 0) begin b_wr = 1'($urandom); b_addr = N'($urandom); b_wdata = N'($urandom); end
      tick();
    end
    reset = 1; a_req = 0; b_req = 0;
    repeat (25) tick();

    check("wr_rd_never_both_low", 64'(overlap), 64'd0);
    check("fast_wr_rd_never_both_low", 64'(f_overlap), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
